pll_lock_seq: RTL and testbench
===============================

Name: pll_lock_seq

Overview:
- Startup and lock-monitor sequencer for the charge-pump PLL (PFD -> charge pump -> loop capacitor).
- Precharges the loop capacitor, then enables the charge pump.
- Watches PFD up/down activity in fixed windows to declare lock, detect loss of lock, and retry or fail on acquisition timeout.
- Sits beside the PFD/CP pair in top_dut and drives their enables.

Parameters:
PRECHG_CYC, 64, refclk cycles precharge_en is held high per attempt
WIN_LEN, 32, refclk cycles per observation window
ERR_TOL, 2, max error cycles in a window for it to count as "good" while acquiring
LOCK_WINS, 4, consecutive good windows required to declare lock
UNLOCK_TOL, 8, error cycles in a window above which it counts as "bad" while locked
UNLOCK_WINS, 2, consecutive bad windows that drop lock
TIMEOUT_WINS, 64, windows allowed per acquisition attempt
MAX_RETRY, 3, retries after first attempt before FAIL

Ports:
refclk  input  1  clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
enable  input  1  sequencer run request, level
up  input  1  PFD up, synchronous to refclk
down  input  1  PFD down, synchronous to refclk
cp_en  output  1  charge-pump enable
precharge_en  output  1  loop-cap precharge-to-midrail enable
lock  output  1  PLL locked
lol_pulse  output  1  one-cycle loss-of-lock strobe
fail  output  1  acquisition failed after all retries
state  output  3  IDLE=0, PRECHARGE=1, ACQUIRE=2, LOCKED=3, FAIL=4
retry_cnt  output  $clog2(MAX_RETRY+1)  retries consumed

Behaviour:
- Reset: rst_n=0 at posedge sets state=IDLE; clears all counters and outputs to 0. Applies in any state, including mid-operation.
- Error sample: err = up ^ down. Both high means PFD reset overlap and is not an error.
- enable=0 in any state: IDLE at next edge, all outputs 0, counters cleared. Takes priority over all other transitions except reset.
- IDLE: all outputs 0, retry_cnt cleared. If enable=1, go to PRECHARGE at next edge.
- PRECHARGE: precharge_en=1, cp_en=0 for exactly PRECHG_CYC cycles.
  - Then go to ACQUIRE. cp_en rises on the same edge precharge_en falls.
  - Window counter, err count, good count and attempt window count are cleared on entry.
- Window mechanics (ACQUIRE and LOCKED):
  - win_cnt runs 0..WIN_LEN-1 and wraps.
  - err_cnt accumulates err each cycle, width $clog2(WIN_LEN+1), no overflow possible.
  - At win_cnt==WIN_LEN-1 the window is evaluated including that cycle's err.
  - err_cnt restarts at 0 for the next window. The result takes effect at the next edge.
- ACQUIRE: cp_en=1.
  - A good window (err_cnt<=ERR_TOL) increments good_wins; any other window clears it.
  - When good_wins reaches LOCK_WINS, go to LOCKED.
  - Each completed window increments att_wins. If TIMEOUT_WINS windows complete without lock:
    - retry_cnt<MAX_RETRY: increment retry_cnt, go to PRECHARGE.
    - otherwise go to FAIL.
  - If lock and timeout are met on the same window, lock wins.
- LOCKED: lock=1, cp_en=1.
  - A bad window (err_cnt>UNLOCK_TOL) increments bad_wins; any other window clears it.
  - When bad_wins reaches UNLOCK_WINS:
    - lock=0 and lol_pulse=1 for exactly one cycle, on the edge entering ACQUIRE.
    - good_wins, att_wins and win_cnt are cleared; retry_cnt is unchanged.
- FAIL: fail=1, cp_en=0, precharge_en=0, lock=0. Held until enable=0 (-> IDLE) or reset.
- All outputs are registered. state reflects the current FSM state.

Test Plan:
- Clean lock: rst_n=0 -> all outputs 0, state=0; then enable=1, up=down=0.
  - precharge_en high exactly 64 cycles, then cp_en=1, state=2.
  - lock=1, state=3 exactly 128 cycles after ACQUIRE entry.
- Tolerance: 2 err cycles in every window -> lock at 128 cycles.
  - 3 err cycles in window 3 -> good count resets, lock at 224 cycles after ACQUIRE entry.
- up=down=1 every cycle in ACQUIRE -> no errors counted, lock at 128 cycles.
- Loss of lock: in LOCKED, 9 err cycles in one window, then a clean window -> lock stays 1.
  - up=1 for two full windows -> lol_pulse high 1 cycle, lock=0, state=2.
  - Clean traffic afterwards -> relock after 4 windows.
- Timeout/fail: up=1 held from enable -> retry_cnt steps 1,2,3, one step every 2112 cycles.
  - fail=1, state=4, cp_en=0 at 8448 cycles after PRECHARGE entry.
  - enable=0 -> IDLE, retry_cnt=0.
- Abort: enable=0 mid-ACQUIRE -> state=0 next edge, cp_en=0.
  - rst_n=0 mid-LOCKED -> lock=0, state=0 next edge.
  - Re-enable -> full 64-cycle precharge repeats.

Source files
------------

// File: rtl/pll_lock_seq.sv
// Startup and lock-monitor sequencer for the charge-pump PLL.
// Precharges the loop capacitor, enables the charge pump, then watches PFD
// up/down activity in fixed windows to declare lock, detect loss of lock,
// and retry or give up when acquisition times out.
//
// Ports:
//   refclk       clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   enable       run request (level); low returns to IDLE
//   up, down     PFD outputs, synchronous to refclk
//   cp_en        charge-pump enable
//   precharge_en loop-cap precharge-to-midrail enable
//   lock         PLL locked
//   lol_pulse    one-cycle loss-of-lock strobe
//   fail         acquisition failed after all retries
//   state        IDLE=0 PRECHARGE=1 ACQUIRE=2 LOCKED=3 FAIL=4
//   retry_cnt    retries consumed
module pll_lock_seq #(
  parameter int unsigned PRECHG_CYC   = 64,
  parameter int unsigned WIN_LEN      = 32,
  parameter int unsigned ERR_TOL      = 2,
  parameter int unsigned LOCK_WINS    = 4,
  parameter int unsigned UNLOCK_TOL   = 8,
  parameter int unsigned UNLOCK_WINS  = 2,
  parameter int unsigned TIMEOUT_WINS = 64,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           up,
  input  logic                           down,
  output logic                           cp_en,
  output logic                           precharge_en,
  output logic                           lock,
  output logic                           lol_pulse,
  output logic                           fail,
  output logic [2:0]                     state,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int unsigned PW = $clog2(PRECHG_CYC);
  localparam int unsigned WW = $clog2(WIN_LEN);
  localparam int unsigned EW = $clog2(WIN_LEN + 1);
  localparam int unsigned GW = $clog2(LOCK_WINS + 1);
  localparam int unsigned BW = $clog2(UNLOCK_WINS + 1);
  localparam int unsigned AW = $clog2(TIMEOUT_WINS + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PRE_LAST     = PW'(PRECHG_CYC - 1);
  localparam logic [WW-1:0] WIN_LAST     = WW'(WIN_LEN - 1);
  localparam logic [EW-1:0] ERR_TOL_W    = EW'(ERR_TOL);
  localparam logic [EW-1:0] UNLOCK_TOL_W = EW'(UNLOCK_TOL);
  localparam logic [GW-1:0] LOCK_WINS_W  = GW'(LOCK_WINS);
  localparam logic [BW-1:0] UNLK_WINS_W  = BW'(UNLOCK_WINS);
  localparam logic [AW-1:0] TIMEOUT_W    = AW'(TIMEOUT_WINS);
  localparam logic [RW-1:0] MAX_RETRY_W  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRECHARGE = 3'd1,
    S_ACQUIRE   = 3'd2,
    S_LOCKED    = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        st;
  logic [PW-1:0] pre_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic [GW-1:0] good_wins;
  logic [BW-1:0] bad_wins;
  logic [AW-1:0] att_wins;

  logic          err;
  logic          win_end;
  logic [EW-1:0] err_sum;
  logic [GW-1:0] good_next;
  logic [BW-1:0] bad_next;
  logic [AW-1:0] att_next;

  assign state = st;

  // Window evaluation includes the current cycle's error sample.
  always_comb begin
    err       = up ^ down;  // both high is PFD reset overlap, not an error
    err_sum   = err_cnt + EW'(err);
    win_end   = (win_cnt == WIN_LAST);
    good_next = (err_sum <= ERR_TOL_W) ? good_wins + GW'(1) : '0;
    bad_next  = (err_sum > UNLOCK_TOL_W) ? bad_wins + BW'(1) : '0;
    att_next  = att_wins + AW'(1);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n || !enable) begin
      st           <= S_IDLE;
      pre_cnt      <= '0;
      win_cnt      <= '0;
      err_cnt      <= '0;
      good_wins    <= '0;
      bad_wins     <= '0;
      att_wins     <= '0;
      retry_cnt    <= '0;
      cp_en        <= 1'b0;
      precharge_en <= 1'b0;
      lock         <= 1'b0;
      lol_pulse    <= 1'b0;
      fail         <= 1'b0;
    end else begin
      lol_pulse <= 1'b0;
      case (st)
        S_IDLE: begin
          st           <= S_PRECHARGE;
          precharge_en <= 1'b1;
          pre_cnt      <= '0;
          retry_cnt    <= '0;
        end
        S_PRECHARGE: begin
          if (pre_cnt == PRE_LAST) begin
            st           <= S_ACQUIRE;
            precharge_en <= 1'b0;
            cp_en        <= 1'b1;
            win_cnt      <= '0;
            err_cnt      <= '0;
            good_wins    <= '0;
            att_wins     <= '0;
          end else begin
            pre_cnt <= pre_cnt + PW'(1);
          end
        end
        S_ACQUIRE: begin
          win_cnt <= win_end ? '0 : win_cnt + WW'(1);
          err_cnt <= win_end ? '0 : err_sum;
          if (win_end) begin
            good_wins <= good_next;
            att_wins  <= att_next;
            // Lock takes precedence over a timeout on the same window.
            if (good_next == LOCK_WINS_W) begin
              st       <= S_LOCKED;
              lock     <= 1'b1;
              bad_wins <= '0;
            end else if (att_next == TIMEOUT_W) begin
              cp_en <= 1'b0;
              if (retry_cnt < MAX_RETRY_W) begin
                st           <= S_PRECHARGE;
                retry_cnt    <= retry_cnt + RW'(1);
                precharge_en <= 1'b1;
                pre_cnt      <= '0;
              end else begin
                st   <= S_FAIL;
                fail <= 1'b1;
              end
            end
          end
        end
        S_LOCKED: begin
          win_cnt <= win_end ? '0 : win_cnt + WW'(1);
          err_cnt <= win_end ? '0 : err_sum;
          if (win_end) begin
            bad_wins <= bad_next;
            if (bad_next == UNLK_WINS_W) begin
              st        <= S_ACQUIRE;
              lock      <= 1'b0;
              lol_pulse <= 1'b1;
              good_wins <= '0;
              att_wins  <= '0;
              bad_wins  <= '0;
            end
          end
        end
        S_FAIL: begin
          fail         <= 1'b1;
          cp_en        <= 1'b0;
          precharge_en <= 1'b0;
          lock         <= 1'b0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_pll_lock_seq;

  logic       refclk;
  logic       rst_n;
  logic       enable;
  logic       up;
  logic       down;
  logic       cp_en;
  logic       precharge_en;
  logic       lock;
  logic       lol_pulse;
  logic       fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  pll_lock_seq dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .up          (up),
    .down        (down),
    .cp_en       (cp_en),
    .precharge_en(precharge_en),
    .lock        (lock),
    .lol_pulse   (lol_pulse),
    .fail        (fail),
    .state       (state),
    .retry_cnt   (retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0d expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Raise enable from IDLE and measure the precharge pulse width.
  task automatic start_seq();
    int n;
    expect_v("precharge_len", 64);
    expect_v("acq_cp_en", 1);
    expect_v("acq_state", 2);
    enable = 1'b1;
    up     = 1'b0;
    down   = 1'b0;
    step(1);
    n = 0;
    while (precharge_en === 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    check_v(n);
    check_v(cp_en);
    check_v(state);
  endtask

  // Drive ACQUIRE traffic: ne error cycles at the start of every window,
  // nb in window bw; both=1 drives up=down=1. Returns cycles until lock.
  task automatic drive_acq(input int ne, input int bw, input int nb,
                           input bit both, input int n0, output int n);
    int w;
    int off;
    int k;
    n = n0;
    while (lock !== 1'b1 && n < 2000) begin
      w    = n / 32;
      off  = n % 32;
      k    = (w == bw) ? nb : ne;
      up   = both ? 1'b1 : (off < k);
      down = both;
      step(1);
      n++;
    end
    up   = 1'b0;
    down = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    step(1);
    start_seq();
  endtask

  initial begin
    int n;
    int pulses;
    int t;
    int tr1;
    int tr2;
    int tr3;
    int tf;

    rst_n  = 1'b0;
    enable = 1'b0;
    up     = 1'b0;
    down   = 1'b0;

    // Reset state
    expect_v("rst_state", 0);
    expect_v("rst_cp_en", 0);
    expect_v("rst_precharge", 0);
    expect_v("rst_lock", 0);
    expect_v("rst_fail", 0);
    expect_v("rst_retry", 0);
    step(2);
    check_v(state);
    check_v(cp_en);
    check_v(precharge_en);
    check_v(lock);
    check_v(fail);
    check_v(retry_cnt);
    rst_n = 1'b1;

    // Clean lock
    start_seq();
    expect_v("clean_lock_cyc", 128);
    expect_v("clean_lock_state", 3);
    drive_acq(0, -1, 0, 1'b0, 0, n);
    check_v(n);
    check_v(state);

    // Loss of lock: one bad window followed by a clean one keeps lock
    expect_v("lol_hold_lock", 1);
    expect_v("lol_hold_state", 3);
    expect_v("lol_hold_pulse", 0);
    for (int i = 0; i < 64; i++) begin
      up = (i < 9);
      step(1);
    end
    up = 1'b0;
    check_v(lock);
    check_v(state);
    check_v(lol_pulse);

    // Two full bad windows drop lock with a single strobe
    expect_v("lol_pulse_count", 1);
    expect_v("lol_pulse_now", 1);
    expect_v("lol_lock", 0);
    expect_v("lol_state", 2);
    expect_v("lol_pulse_after", 0);
    expect_v("relock_cyc", 128);
    pulses = 0;
    up = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (lol_pulse === 1'b1) pulses++;
    end
    check_v(pulses);
    check_v(lol_pulse);
    check_v(lock);
    check_v(state);
    up = 1'b0;
    step(1);
    check_v(lol_pulse);
    drive_acq(0, -1, 0, 1'b0, 1, n);
    check_v(n);

    // Tolerance: 2 errors per window still counts as good
    restart();
    expect_v("tol2_lock_cyc", 128);
    drive_acq(2, -1, 0, 1'b0, 0, n);
    check_v(n);

    // 3 errors in window 3 resets the good count
    restart();
    expect_v("tol3_lock_cyc", 224);
    drive_acq(2, 2, 3, 1'b0, 0, n);
    check_v(n);

    // up=down=1 overlap is not an error
    restart();
    expect_v("overlap_lock_cyc", 128);
    drive_acq(0, -1, 0, 1'b1, 0, n);
    check_v(n);

    // Timeout: up held high from enable through all retries
    enable = 1'b0;
    step(1);
    expect_v("to_prech_state", 1);
    expect_v("to_retry1_cyc", 2112);
    expect_v("to_retry2_cyc", 4224);
    expect_v("to_retry3_cyc", 6336);
    expect_v("to_fail_cyc", 8448);
    expect_v("to_fail_state", 4);
    expect_v("to_fail_cp_en", 0);
    expect_v("to_fail_prech", 0);
    enable = 1'b1;
    up     = 1'b1;
    step(1);
    check_v(state);
    t   = 0;
    tr1 = -1;
    tr2 = -1;
    tr3 = -1;
    tf  = -1;
    while (fail !== 1'b1 && t < 9000) begin
      step(1);
      t++;
      if (retry_cnt == 2'd1 && tr1 < 0) tr1 = t;
      if (retry_cnt == 2'd2 && tr2 < 0) tr2 = t;
      if (retry_cnt == 2'd3 && tr3 < 0) tr3 = t;
    end
    if (fail === 1'b1) tf = t;
    check_v(tr1);
    check_v(tr2);
    check_v(tr3);
    check_v(tf);
    check_v(state);
    check_v(cp_en);
    check_v(precharge_en);

    expect_v("fail_exit_state", 0);
    expect_v("fail_exit_retry", 0);
    expect_v("fail_exit_fail", 0);
    up     = 1'b0;
    enable = 1'b0;
    step(1);
    check_v(state);
    check_v(retry_cnt);
    check_v(fail);

    // Abort: enable dropped mid-ACQUIRE
    start_seq();
    step(10);
    expect_v("abort_state", 0);
    expect_v("abort_cp_en", 0);
    enable = 1'b0;
    step(1);
    check_v(state);
    check_v(cp_en);

    // Reset mid-LOCKED, then re-enable repeats the full precharge
    start_seq();
    expect_v("rst_lock_cyc", 128);
    drive_acq(0, -1, 0, 1'b0, 0, n);
    check_v(n);
    expect_v("midrst_lock", 0);
    expect_v("midrst_state", 0);
    rst_n = 1'b0;
    step(1);
    check_v(lock);
    check_v(state);
    rst_n = 1'b1;
    start_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
